// File: rtl/rom_boot_loader_pkg.sv
// Shared types for the ROM boot loader: FSM state encoding and error codes.
package rom_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // States in which the loader is consuming bytes from the host link.
  function automatic logic is_rx(state_e s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
  endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Host byte link, ROM write port and CPU/status signals of the boot loader.
interface rom_boot_loader_if #(parameter int ADDR_W = 15);
  import rom_boot_loader_pkg::*;

  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, rom_we, rom_addr, rom_wdata,
    input  cpu_rst_n, busy, done, err, err_code
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, rom_we, rom_addr, rom_wdata,
    output cpu_rst_n, busy, done, err, err_code
  );
endinterface

// File: rtl/rom_boot_loader_timeout_timer.sv
// Idle-cycle counter: flags the cycle in which TIMEOUT idle cycles have elapsed.
module boot_timeout_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rom_boot_loader.sv
// Loads a length-prefixed, checksummed byte stream into the instruction ROM and
// releases the CPU from reset only after a complete, verified image.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1_000_000
) (
  input logic              clk,
  input logic              rst_n,
  rom_boot_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        hi_q, sum_q;
  logic [ADDR_W-1:0] idx_q, last_q, addr_q;
  logic [15:0]       wdata_q;
  logic              we_q, ready_q, busy_q, done_q, err_q, cpu_rst_n_q;

  logic        rx, xfer, tmo, len_bad;
  logic [15:0] len_w;

  assign rx      = is_rx(state_q);
  assign xfer    = ready_q && bus.byte_valid;
  assign len_w   = {hi_q, bus.byte_in};
  assign len_bad = (len_w == 16'd0) || (17'(len_w) > 17'(DEPTH));

  boot_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!rx || xfer),
    .enable_i (rx && !xfer),
    .expired_o(tmo)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (bus.start) begin
          state_d = ST_LEN_HI;
          code_d  = ERR_NONE;
        end
      ST_LEN_HI:  if (xfer) state_d = ST_LEN_LO;
      ST_LEN_LO:
        if (xfer) begin
          if (len_bad) begin
            state_d = ST_ERROR;
            code_d  = ERR_LEN;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      ST_DATA_HI: if (xfer) state_d = ST_DATA_LO;
      ST_DATA_LO: if (xfer) state_d = (idx_q == last_q) ? ST_CSUM : ST_DATA_HI;
      ST_CSUM:
        if (xfer) begin
          if (bus.byte_in == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            code_d  = ERR_CSUM;
          end
        end
      default: state_d = ST_IDLE;
    endcase
    // A transfer in the expiry cycle takes precedence over the timeout.
    if (rx && !xfer && tmo) begin
      state_d = ST_ERROR;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= ERR_NONE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ready_q     <= is_rx(state_d);
      busy_q      <= is_rx(state_d);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERROR);
      cpu_rst_n_q <= (state_d == ST_DONE);
      we_q        <= 1'b0;

      if (!rx && bus.start) begin
        idx_q  <= '0;
        addr_q <= '0;
        sum_q  <= '0;
      end

      if (xfer) begin
        case (state_q)
          ST_LEN_HI:  hi_q   <= bus.byte_in;
          ST_LEN_LO:  last_q <= ADDR_W'(len_w - 16'd1);
          ST_DATA_HI: begin
            hi_q  <= bus.byte_in;
            sum_q <= sum_q + bus.byte_in;
          end
          ST_DATA_LO: begin
            we_q    <= 1'b1;
            addr_q  <= idx_q;
            wdata_q <= {hi_q, bus.byte_in};
            sum_q   <= sum_q + bus.byte_in;
            // Holding the index on the last word keeps a full-depth image from wrapping.
            if (idx_q != last_q) idx_q <= idx_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.rom_we     = we_q;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_wdata  = wdata_q;
endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: table-driven frames, hand-written corner sequences
// and randomized images checked against a frame-level reference model.
module tb_rom_boot_loader;
  localparam int AW    = 15;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_boot_loader_if #(.ADDR_W(AW)) bus();

  rom_boot_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int          wa[$];
  logic [15:0] wd[$];
  int          exp_wa[$];
  logic [15:0] exp_wd[$];
  logic [7:0]  fb[$];
  int          fg[$];
  logic [15:0] words[$];

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [15:0] base;
    bit          cs_bad;
    logic [1:0]  exp_code;
    bit          exp_done;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[8];

  // Observed ROM writes.
  always @(negedge clk) begin
    if (rst_n && bus.rom_we) begin
      wa.push_back(int'(bus.rom_addr));
      wd.push_back(bus.rom_wdata);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: walks the byte list using the frame rules directly.
  task automatic model(output logic [1:0] code, output bit dn);
    int n;
    logic [7:0] sum, hi;
    bit fin;
    n = 0; sum = 8'd0; hi = 8'd0; fin = 1'b0; code = 2'b00; dn = 1'b0;
    exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < fb.size(); i++) begin
      if (!fin) begin
        if (fg[i] >= TO) begin
          code = 2'b11; fin = 1'b1;
        end else if (i == 0) begin
          hi = fb[i];
        end else if (i == 1) begin
          n = int'({hi, fb[i]});
          if (n == 0 || n > DEPTH) begin
            code = 2'b01; fin = 1'b1;
          end
        end else if (i < 2 + 2 * n) begin
          sum = sum + fb[i];
          if ((i - 2) % 2 == 1) begin
            exp_wa.push_back((i - 2) / 2);
            exp_wd.push_back({fb[i-1], fb[i]});
          end
        end else begin
          if (fb[i] == sum) dn = 1'b1;
          else code = 2'b10;
          fin = 1'b1;
        end
      end
    end
    if (!fin) code = 2'b11;
  endtask

  // gmode 0: no gaps, 1: short gaps with occasional long ones, 2: may exceed TIMEOUT.
  task automatic make_frame(input logic [15:0] len, input int nw, input bit cs_bad, input int gmode);
    logic [7:0] s;
    s = 8'd0;
    fb.delete(); fg.delete();
    fb.push_back(len[15:8]);
    fb.push_back(len[7:0]);
    for (int k = 0; k < nw; k++) begin
      fb.push_back(words[k][15:8]);
      fb.push_back(words[k][7:0]);
      s = s + words[k][15:8] + words[k][7:0];
    end
    if (len != 16'd0 && int'(len) <= DEPTH && nw == int'(len))
      fb.push_back(cs_bad ? (s ^ 8'h01) : s);
    for (int i = 0; i < fb.size(); i++) begin
      case (gmode)
        0: fg.push_back(0);
        1: fg.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(8, TO - 1))
                                                     : int'($urandom_range(0, 2)));
        default: fg.push_back(($urandom_range(0, 39) == 0) ? int'($urandom_range(TO, TO + 2))
                                                            : int'($urandom_range(0, TO - 1)));
      endcase
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Idles for gap cycles (optionally pulsing start in the first), then offers the byte.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid);
    for (int g = 0; g < gap; g++) begin
      bus.start = mid && (g == 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (bus.byte_ready) begin
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic drive_frame(input int mid);
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], fg[i], i == mid);
    repeat (TO + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_outcome(input string tag, input logic [1:0] ec, input bit ed);
    chk({tag, "_done"},      bus.done, ed);
    chk({tag, "_err"},       bus.err, ec != 2'b00);
    chk({tag, "_err_code"},  bus.err_code, ec);
    chk({tag, "_cpu_rst_n"}, bus.cpu_rst_n, ed);
    chk({tag, "_busy"},      bus.busy, 1'b0);
    chk({tag, "_nwrites"},   wa.size(), exp_wa.size());
    if (wa.size() == exp_wa.size()) begin
      for (int k = 0; k < wa.size(); k++) begin
        chk($sformatf("%s_addr%0d", tag, k), wa[k], exp_wa[k]);
        chk($sformatf("%s_data%0d", tag, k), wd[k], exp_wd[k]);
      end
    end
  endtask

  initial begin
    logic [1:0] mc;
    bit md;
    int len, mid;

    bus.start = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    vecs[0] = '{16'd2,    2, 16'h1234, 1'b0, 2'b00, 1'b1, 2};
    vecs[1] = '{16'd2,    2, 16'h1234, 1'b1, 2'b10, 1'b0, 2};
    vecs[2] = '{16'd0,    0, 16'h0000, 1'b0, 2'b01, 1'b0, 0};
    vecs[3] = '{16'h8001, 0, 16'h0000, 1'b0, 2'b01, 1'b0, 0};
    vecs[4] = '{16'h8000, 2, 16'hBEEF, 1'b0, 2'b11, 1'b0, 2};
    vecs[5] = '{16'd1,    1, 16'hA5A5, 1'b0, 2'b00, 1'b1, 1};
    vecs[6] = '{16'd3,    3, 16'h00FF, 1'b1, 2'b10, 1'b0, 3};
    vecs[7] = '{16'd4,    1, 16'h5555, 1'b0, 2'b11, 1'b0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.byte_ready, 1'b0);
    chk("rst_cpu_rst_n", bus.cpu_rst_n, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_err_code", bus.err_code, 2'b00);
    chk("rst_rom_we", bus.rom_we, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference frame: 00 02 | 00 03 EC 10 | CS = 0x00+0x03+0xEC+0x10 = 0xFF
    wa.delete(); wd.delete();
    fb = '{8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10};
    pulse_start();
    chk("t1_busy", bus.busy, 1'b1);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 0, 1'b0);
    bus.byte_in = 8'hFF; bus.byte_valid = 1'b1;
    chk("t1_cpu_held_pre_cs", bus.cpu_rst_n, 1'b0);
    chk("t1_ready_at_cs", bus.byte_ready, 1'b1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    chk("t1_cpu_released", bus.cpu_rst_n, 1'b1);
    chk("t1_done", bus.done, 1'b1);
    chk("t1_busy_after", bus.busy, 1'b0);
    chk("t1_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("t1_addr0", wa[0], 0);
      chk("t1_data0", wd[0], 16'h0003);
      chk("t1_addr1", wa[1], 1);
      chk("t1_data1", wd[1], 16'hEC10);
    end

    // Start from DONE re-holds the CPU and clears done; starved load then times out.
    pulse_start();
    chk("restart_cpu_held", bus.cpu_rst_n, 1'b0);
    chk("restart_done_clr", bus.done, 1'b0);
    chk("restart_busy", bus.busy, 1'b1);
    repeat (TO + 4) @(posedge clk);
    #1;
    chk("restart_timeout_code", bus.err_code, 2'b11);

    // Table-driven frames
    foreach (vecs[v]) begin
      words.delete();
      for (int k = 0; k < vecs[v].nw; k++) words.push_back(vecs[v].base + 16'(k) * 16'h0101);
      make_frame(vecs[v].len, vecs[v].nw, vecs[v].cs_bad, 0);
      model(mc, md);
      drive_frame(-1);
      chk($sformatf("vec%0d_code", v), bus.err_code, vecs[v].exp_code);
      chk($sformatf("vec%0d_done", v), bus.done, vecs[v].exp_done);
      chk($sformatf("vec%0d_nwr", v), wa.size(), vecs[v].exp_nwr);
      check_outcome($sformatf("vec%0d", v), mc, md);
    end

    // Timeout boundary: 16 idle cycles after a HI byte expire the load.
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, TO, 1'b0);
    chk("t4_stall_err", bus.err, 1'b1);
    chk("t4_stall_code", bus.err_code, 2'b11);
    chk("t4_stall_nwr", wa.size(), 0);
    // A byte arriving on the last idle cycle wins over the timeout.
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, TO - 1, 1'b0);
    chk("t4_edge_busy", bus.busy, 1'b1);
    chk("t4_edge_err", bus.err, 1'b0);
    send_byte(8'h46, 0, 1'b0);
    chk("t4_edge_done", bus.done, 1'b1);
    chk("t4_edge_code", bus.err_code, 2'b00);
    chk("t4_edge_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("t4_edge_data", wd[0], 16'h1234);

    // 100-word image with random gaps and a start pulse in the middle.
    words.delete();
    for (int k = 0; k < 100; k++) words.push_back(16'($urandom));
    make_frame(16'd100, 100, 1'b0, 1);
    mid = 101;
    if (fg[mid] < 1) fg[mid] = 1;
    model(mc, md);
    drive_frame(mid);
    chk("big_done_expected", bus.done, 1'b1);
    check_outcome("big", mc, md);

    // Random frames: may be truncated, corrupt or stall past the timeout.
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 12));
      words.delete();
      for (int k = 0; k < len; k++) words.push_back(16'($urandom));
      make_frame(16'(len), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : len,
                 $urandom_range(0, 2) == 0, 2);
      model(mc, md);
      drive_frame(-1);
      check_outcome($sformatf("rnd%0d", r), mc, md);
    end

    // Reset during word 5 of an 8-word load.
    words.delete();
    for (int k = 0; k < 8; k++) words.push_back(16'h0100 + 16'(k));
    make_frame(16'd8, 8, 1'b0, 0);
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < 13; i++) send_byte(fb[i], 0, 1'b0);
    bus.byte_in = fb[13]; bus.byte_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", bus.busy, 1'b0);
    chk("t6_async_ready", bus.byte_ready, 1'b0);
    chk("t6_async_cpu", bus.cpu_rst_n, 1'b0);
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_done", bus.done, 1'b0);
    chk("t6_rst_err", bus.err, 1'b0);
    chk("t6_rst_code", bus.err_code, 2'b00);
    chk("t6_rst_we", bus.rom_we, 1'b0);
    chk("t6_rst_addr", bus.rom_addr, 0);
    chk("t6_rst_wdata", bus.rom_wdata, 16'h0000);
    chk("t6_partial_nwr", wa.size(), 5);
    rst_n = 1'b1;
    @(posedge clk); #1;
    words.delete();
    words.push_back(16'hC0DE);
    make_frame(16'd1, 1, 1'b0, 0);
    model(mc, md);
    drive_frame(-1);
    chk("t6_reload_done", bus.done, 1'b1);
    check_outcome("t6_reload", mc, md);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
